// File: rtl/key_expander.sv
// AES key-schedule writer: expands a 128/192/256-bit key one word per cycle and
// streams packed 128-bit round keys to the round-key memory controller.

module key_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
    always_comb begin
        sq  = x;
        inv = 8'h01;
        for (int n = 1; n < 8; n++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_expander (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key,
    output logic [127:0] rkey_out,
    output logic         wr_enable,
    output logic         increase,
    output logic         init,
    output logic         keygen,
    output logic         last_key,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, INIT, GEN, DONE} state_t;

    state_t      state;
    logic [31:0] win [8];
    logic [95:0] asm_reg;
    logic [5:0]  idx;
    logic [5:0]  nw;
    logic [2:0]  jdx;
    logic [3:0]  nk;
    logic [7:0]  rcon;
    logic        fin;

    logic [31:0] prev, back, sub_in, sub_out, temp, word;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // window: win[7] is w[i-1], win[8-Nk] is w[i-Nk]; win[0] holds key word i while i < Nk
    always_comb begin
        prev = win[7];
        case (nk)
            4'd6:    back = win[2];
            4'd8:    back = win[0];
            default: back = win[4];
        endcase
        sub_in = (jdx == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        temp   = prev;
        if (jdx == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && jdx == 3'd4)
            temp = sub_out;
        word = (idx < {2'b00, nk}) ? win[0] : (back ^ temp);
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        key_sbox u_sbox (.x(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rkey_out  <= '0;
            wr_enable <= 1'b0;
            increase  <= 1'b0;
            init      <= 1'b0;
            keygen    <= 1'b0;
            last_key  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            asm_reg   <= '0;
            idx       <= '0;
            jdx       <= '0;
            nk        <= 4'd4;
            nw        <= 6'd44;
            rcon      <= 8'h01;
            fin       <= 1'b0;
            for (int k = 0; k < 8; k++) win[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= INIT;
                        init   <= 1'b1;
                        keygen <= 1'b1;
                        busy   <= 1'b1;
                        case (mode)
                            2'h2:    begin nk <= 4'd6; nw <= 6'd52; end
                            2'h3:    begin nk <= 4'd8; nw <= 6'd60; end
                            default: begin nk <= 4'd4; nw <= 6'd44; end
                        endcase
                        for (int k = 0; k < 8; k++) win[k] <= key[255 - 32*k -: 32];
                    end
                end
                INIT: begin
                    init  <= 1'b0;
                    idx   <= '0;
                    jdx   <= '0;
                    rcon  <= 8'h01;
                    state <= GEN;
                end
                GEN: begin
                    for (int k = 0; k < 7; k++) win[k] <= win[k+1];
                    win[7]    <= word;
                    asm_reg   <= {asm_reg[63:0], word};
                    idx       <= idx + 6'd1;
                    jdx       <= ({1'b0, jdx} == nk - 4'd1) ? 3'd0 : jdx + 3'd1;
                    if (idx >= {2'b00, nk} && jdx == 3'd0) rcon <= xtime(rcon);
                    wr_enable <= (idx[1:0] == 2'd3);
                    increase  <= (idx[1:0] == 2'd3);
                    if (idx[1:0] == 2'd3) rkey_out <= {asm_reg, word};
                    if (idx == nw - 6'd1) begin
                        state    <= DONE;
                        last_key <= 1'b1;
                        fin      <= 1'b0;
                    end
                end
                DONE: begin
                    // first cycle carries the final write, second carries done
                    if (!fin) begin
                        wr_enable <= 1'b0;
                        increase  <= 1'b0;
                        last_key  <= 1'b0;
                        keygen    <= 1'b0;
                        done      <= 1'b1;
                        fin       <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_expander.sv
// Randomized bench for key_expander: cycle-exact strobe checks and round keys
// compared against an array-based FIPS-197 key-expansion model.

module tb_key_expander;
    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] rkey_out;
    logic         wr_enable, increase, init, keygen, last_key, busy, done;

    key_expander dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
        .rkey_out(rkey_out), .wr_enable(wr_enable), .increase(increase),
        .init(init), .keygen(keygen), .last_key(last_key), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0]  mw [60];
    logic [127:0] got_keys [15];
    logic [127:0] exp_hold;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // S-box from the multiply-by-3 / divide-by-3 generator walk
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    task automatic build_model(input int nk, input logic [255:0] k);
        logic [31:0] t;
        int nw;
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = subw(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    task automatic run(input logic [1:0] m, input logic [255:0] k, input bit disturb,
                       input int abort_at, input string name);
        int nk, nw, tf, r;
        bit wr_exp;
        logic [6:0] ctl_exp, ctl_got;
        nk = (m == 2'h2) ? 6 : (m == 2'h3) ? 8 : 4;
        nw = 4 * (nk + 7);
        tf = nw + 2;
        build_model(nk, k);
        @(negedge clk);
        start = 1'b1; mode = m; key = k;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= tf + 2; c++) begin
            wr_exp  = (c >= 6) && (c <= tf) && ((c - 6) % 4 == 0);
            r       = (c - 6) / 4;
            ctl_exp = {c == 1, c <= tf, wr_exp, wr_exp, c == tf, c == tf + 1, c <= tf + 1};
            ctl_got = {init, keygen, wr_enable, increase, last_key, done, busy};
            check($sformatf("%s ctl c=%0d", name, c), ctl_got, ctl_exp);
            if (wr_exp) begin
                exp_hold = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
                got_keys[r] = rkey_out;
            end
            check($sformatf("%s rkey c=%0d", name, c), rkey_out, exp_hold);
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check({name, " rst rkey"}, rkey_out, 128'h0);
                check({name, " rst ctl"}, {init, keygen, wr_enable, increase, last_key, done, busy}, 7'h0);
                @(negedge clk);
                rst = 1'b0;
                exp_hold = '0;
                return;
            end
            if (disturb && c <= tf) begin
                start = 1'($urandom_range(0, 1));
                key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                mode  = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    logic [255:0] k128, k192, k256, rk;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'h0; key = '0;
        exp_hold = '0;
        build_sbox();
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        repeat (3) @(posedge clk);
        #1;
        check("reset rkey", rkey_out, 128'h0);
        check("reset ctl", {init, keygen, wr_enable, increase, last_key, done, busy}, 7'h0);
        @(negedge clk);
        rst = 1'b0;

        run(2'h0, k128, 1'b0, 0, "aes128");
        check("aes128 w0", got_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("aes128 w1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("aes128 w10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(2'h2, k192, 1'b0, 0, "aes192");
        check("aes192 w12", got_keys[12], 128'he98ba06f448c773c8ecc720401002202);

        run(2'h3, k256, 1'b0, 0, "aes256");
        check("aes256 w14", got_keys[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run(2'h1, k128, 1'b1, 0, "mode1 disturbed");
        check("mode1 w10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(2'h0, k128, 1'b0, 26, "abort");
        run(2'h0, k128, 1'b0, 0, "after abort");
        check("after abort w10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int n = 0; n < 8; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run(2'($urandom_range(0, 3)), rk, 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_expander.md
# key_expander

Round-key generator that writes the AES key schedule into the round-key memory controller. On `start` it expands a 128/192/256-bit cipher key per FIPS-197, one 32-bit word per cycle, packs four words into each 128-bit round key, and drives the controller's `init`/`keygen`/`wr_enable`/`increase`/`last_key` inputs so round key r lands at address r. It is the writer side of the round-key memory; the cipher datapath is the reader.

## Interface
Parameters: none (mode is a run-time input).
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  request expansion; accepted only in IDLE
- mode  in  2  2'h2 AES-192, 2'h3 AES-256, any other value AES-128; sampled on accepted start
- key  in  256  cipher key, MSB-first; w0 = key[255:224]; AES-128 uses key[255:128], AES-192 uses key[255:64]; sampled on accepted start
- rkey_out  out  128  round key to memory; [127:96] = w[4r], [31:0] = w[4r+3]
- wr_enable  out  1  write strobe, one cycle per round key
- increase  out  1  address advance, asserted with wr_enable
- init  out  1  one-cycle pulse, resets controller address to 0
- keygen  out  1  high from init cycle through final write (selects forward addressing)
- last_key  out  1  high with the final wr_enable
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after final write

## Operation
- States: IDLE -> INIT -> GEN -> DONE -> IDLE.
- IDLE: all strobes low; start=1 -> INIT, latch mode, Nk (4/6/8), total words Nw (44/52/60), load key words into 8x32 window.
- INIT: init=1, keygen=1 for one cycle; word index i=0, Nk-phase counter j=0, rcon=8'h01 -> GEN.
- GEN, one word per cycle:
  - i < Nk: word = key word i.
  - else temp = w[i-1]; if j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon) (01,02,04,08,10,20,40,80,1B,36); else if Nk==8 and j==4: temp = SubWord(temp).
  - word = w[i-Nk] ^ temp.
  - Shift word into window; shift into 128-bit assembly register; j wraps Nk-1 -> 0 (no division); i increments.
  - When i%4==3, next cycle: rkey_out = assembled key, wr_enable=increase=1.
  - After word Nw-1 -> DONE.
- DONE: final write (last_key=1) is issued in this cycle; then done=1 for one cycle -> IDLE.
- SubWord: four byte-wise AES forward S-box lookups (four instances of the team's combinational sbox).
- Round keys written: 11 / 13 / 15; last address A / C / E.
- start while busy: ignored; key/mode changes after acceptance: ignored.

## Timing
- Reset: all outputs 0, rkey_out 128'h0, state IDLE, rcon 8'h01.
- Outputs registered; no combinational path from inputs to outputs.
- Start sampled at edge T: init/keygen at cycle T+1; word i computed in cycle T+2+i.
- Write for round r at cycle T+6+4r; final write at T+46 (AES-128), T+54 (AES-192), T+62 (AES-256); done one cycle later; IDLE, start accepted, the following cycle.
- keygen high T+1 through final write inclusive; busy high T+1 through done cycle.
- wr_enable and increase are never asserted outside GEN/DONE and never on consecutive cycles.
- rkey_out holds its last written value between writes.
- rst mid-run: immediate return to IDLE, no further strobes; next start restarts from init.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> write 0 = same key, write 1 = a0fafe1788542cb123a339392a6c7605, write 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with last_key; 11 writes total; done at T+47.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 writes; write 12 = e98ba06f448c773c8ecc720401002202 with last_key.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 writes; write 14 = fe4890d1e6188d0b046df344706c631e; checks the j==4 SubWord path.
- mode=2'h0 and 2'h1 behave as AES-128; start pulsed mid-run and key changed mid-run -> output stream identical to an undisturbed run.
- rst asserted at the cycle of write 5 -> all outputs 0 next cycle; new start -> full correct sequence beginning with init.
- Integration with the memory controller (enc=0, keygen path): readback of addresses 0..A matches the FIPS-197 schedule.
